// File: rtl/bram_readout.sv
// Streams BRAM addresses 0..count_max out over AXI-Stream, with credit-based issue into a small skid FIFO.
// Optional BRAM_READOUT_CLEAR_EN: write zero to each address as it is read.
module bram_readout #(
  parameter int BRAM_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BRAM_WIDTH-1:0] count_max,
  output logic [BRAM_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = READ_LATENCY + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_next;
  logic [BRAM_WIDTH-1:0]   addr, count_last;
  logic [READ_LATENCY-1:0] pipe_vld, pipe_last;
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic                    last_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count, in_flight;
  logic [CNT_W:0]          occupancy;
  logic                    credit, fifo_wr, fifo_rd, issue_last;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every issued read already owns a FIFO slot, so tready stalls can never overflow the FIFO.
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++)
      in_flight = in_flight + CNT_W'(pipe_vld[i]);
    occupancy = {1'b0, fifo_count} + {1'b0, in_flight};
    credit    = occupancy < (CNT_W + 1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)                     state_next = ISSUE;
      ISSUE:   if (bram_en && issue_last)     state_next = DRAIN;
      DRAIN:   if (fifo_rd && m_axis_tlast)   state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  always_comb begin
    bram_en = (state == ISSUE) && credit;
    busy    = (state != IDLE);
  end

  assign issue_last = (addr == count_last);
  assign bram_addr  = addr;
  assign bram_wdata = '0;
`ifdef BRAM_READOUT_CLEAR_EN
  assign bram_we = bram_en;
`else
  assign bram_we = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr       <= '0;
      count_last <= '0;
      done       <= 1'b0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
    end else begin
      if (state == IDLE && start) begin
        count_last <= count_max;
        addr       <= '0;
      end else if (bram_en && !issue_last) begin
        addr <= addr + 1'b1;
      end
      done         <= (state == DRAIN) && fifo_rd && m_axis_tlast;
      pipe_vld[0]  <= bram_en;
      pipe_last[0] <= bram_en && issue_last;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign fifo_wr = pipe_vld[READ_LATENCY-1];
  assign fifo_rd = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      data_q[wr_ptr] <= bram_rdata;
      last_q[wr_ptr] <= pipe_last[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= bump(wr_ptr);
      if (fifo_rd) rd_ptr <= bump(rd_ptr);
      if (fifo_wr && !fifo_rd)      fifo_count <= fifo_count + 1'b1;
      else if (!fifo_wr && fifo_rd) fifo_count <= fifo_count - 1'b1;
    end
  end

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? data_q[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_q[rd_ptr];

endmodule

// File: tb/tb_bram_readout.sv
// Directed bench for bram_readout: READ_FIRST BRAM model (addr -> addr+100), READ_LATENCY=2.
module tb_bram_readout;

  logic        clk = 1'b0;
  logic        resetn, start, m_axis_tready;
  logic [12:0] count_max, bram_addr;
  logic        bram_en, bram_we, m_axis_tvalid, m_axis_tlast, busy, done;
  logic [31:0] bram_wdata, bram_rdata, m_axis_tdata;

  bram_readout #(.BRAM_WIDTH(13), .DATA_WIDTH(32), .READ_LATENCY(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .count_max(count_max),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8192];
  logic [31:0] rd_pipe [2];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 32'(i + 100);
    end else if (bram_en && bram_we) begin
      mem[bram_addr] <= '0;
    end
    if (bram_en) rd_pipe[0] <= mem[bram_addr];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign bram_rdata = rd_pipe[1];

  int checks = 0;
  int errors = 0;
  logic [31:0] got_data [$];
  logic        got_last [$];
  int done_cnt, done_k, first_valid, last_xfer_k, stall_err;
  logic busy_k0, busy_after;
  logic [3:0] pat = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reinit();
    @(posedge clk); #1 mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
  endtask

  // k=0 is the sample just after the edge that accepts start
  task automatic run(input logic [12:0] cm, input bit stall, input int restart_k, input int budget);
    logic        held = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    got_data.delete(); got_last.delete();
    done_cnt = 0; done_k = -1; first_valid = -1; last_xfer_k = -1; stall_err = 0;
    busy_k0 = 1'b0; busy_after = 1'b1;
    @(posedge clk); #1 start = 1'b1; count_max = cm; m_axis_tready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      start = (k == restart_k);
      if (restart_k >= 0 && k >= restart_k) count_max = 13'd3;
      m_axis_tready = stall ? pat[k % 4] : 1'b1;
      if (k == 0) busy_k0 = busy;
      if (held && (m_axis_tdata !== hd || m_axis_tlast !== hl)) stall_err++;
      if (m_axis_tvalid && first_valid < 0) first_valid = k;
      if (done) begin done_cnt++; done_k = k; busy_after = busy; end
      if (m_axis_tvalid && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        if (m_axis_tlast) last_xfer_k = k;
      end
      held = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata; hl = m_axis_tlast;
    end
  endtask

  task automatic check_words(input string tag, input int n, input bit zero_data);
    check({tag, "_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), zero_data ? 64'd0 : 64'(i + 100));
      check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    int bad, nlast;
    resetn = 1'b0; start = 1'b0; count_max = '0; m_axis_tready = 1'b0;
    reinit();
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_done",   64'(done),          64'd0);
    check("rst_en",     64'(bram_en),       64'd0);
    check("rst_addr",   64'(bram_addr),     64'd0);
    check("rst_wdata",  64'(bram_wdata),    64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // back-to-back stream, tready held high
    reinit();
    run(13'd7, 1'b0, -1, 40);
    check_words("full_rate", 8, 1'b0);
    check("first_valid", 64'(first_valid), 64'd3);
    check("last_xfer_k", 64'(last_xfer_k), 64'd10);
    check("done_cnt",    64'(done_cnt),    64'd1);
    check("done_k",      64'(done_k),      64'd11);
    check("busy_rise",   64'(busy_k0),     64'd1);
    check("busy_drop",   64'(busy_after),  64'd0);

    // tready 1,0,0,1 repeating
    reinit();
    run(13'd7, 1'b1, -1, 60);
    check_words("stall", 8, 1'b0);
    check("stall_stable",   64'(stall_err), 64'd0);
    check("stall_done_cnt", 64'(done_cnt),  64'd1);

    // single word
    reinit();
    run(13'd0, 1'b0, -1, 20);
    check_words("single", 1, 1'b0);
    check("single_first",  64'(first_valid), 64'd3);
    check("single_done_k", 64'(done_k),      64'd4);
    check("single_dcnt",   64'(done_cnt),    64'd1);

    // restart while busy with a new count_max is ignored
    reinit();
    run(13'd7, 1'b0, 2, 40);
    check_words("restart", 8, 1'b0);
    check("restart_dcnt", 64'(done_cnt), 64'd1);

    // reset after four transfers
    reinit();
    @(posedge clk); #1 start = 1'b1; count_max = 13'd7; m_axis_tready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_tdata", 64'(m_axis_tdata), 64'd104);
    resetn = 1'b0;
    #1;
    check("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mrst_tlast",  64'(m_axis_tlast),  64'd0);
    check("mrst_tdata",  64'(m_axis_tdata),  64'd0);
    check("mrst_busy",   64'(busy),          64'd0);
    check("mrst_en",     64'(bram_en),       64'd0);
    check("mrst_addr",   64'(bram_addr),     64'd0);
    check("mrst_we",     64'(bram_we),       64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    run(13'd2, 1'b0, -1, 20);
    check_words("after_rst", 3, 1'b0);
    check("after_rst_first", 64'(first_valid), 64'd3);

    // entire BRAM, no wrap past the top address
    reinit();
    run(13'h1fff, 1'b0, -1, 8220);
    bad = 0; nlast = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== 32'(i + 100)) bad++;
      if (got_last[i] === 1'b1) nlast++;
    end
    check("big_count",  64'(got_data.size()), 64'd8192);
    check("big_badata", 64'(bad),             64'd0);
    check("big_nlast",  64'(nlast),           64'd1);
    check("big_lastk",  64'(last_xfer_k),     64'd8194);
    check("big_dcnt",   64'(done_cnt),        64'd1);

    // second pass shows whether the read cleared the BRAM
    reinit();
    run(13'd3, 1'b0, -1, 20);
    check_words("pass1", 4, 1'b0);
    run(13'd3, 1'b0, -1, 20);
`ifdef BRAM_READOUT_CLEAR_EN
    check_words("pass2", 4, 1'b1);
`else
    check_words("pass2", 4, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_readout.md
BRAM_READOUT -- requirements
Module: bram_readout

Interface
REQ-001 SHALL have parameter BRAM_WIDTH, default 13, address/count width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM data and stream width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, BRAM clock cycles from bram_en to valid bram_rdata; legal range 1..3.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port `resetn`, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port `start`, input, 1 bit: single-cycle request to read out one capture.
REQ-007 SHALL have port `count_max`, input, BRAM_WIDTH bits: last address to read; sampled on an accepted start.
REQ-008 SHALL have port `bram_addr`, output, BRAM_WIDTH bits: BRAM read address.
REQ-009 SHALL have port `bram_en`, output, 1 bit: BRAM read enable.
REQ-010 SHALL have port `bram_we`, output, 1 bit: BRAM write enable (see Configuration).
REQ-011 SHALL have port `bram_wdata`, output, DATA_WIDTH bits: always 0.
REQ-012 SHALL have port `bram_rdata`, input, DATA_WIDTH bits: BRAM read data.
REQ-013 SHALL have port `m_axis_tdata`, output, DATA_WIDTH bits: stream data.
REQ-014 SHALL have port `m_axis_tvalid`, output, 1 bit: stream valid.
REQ-015 SHALL have port `m_axis_tready`, input, 1 bit: stream ready.
REQ-016 SHALL have port `m_axis_tlast`, output, 1 bit: marks the word read from address count_max.
REQ-017 SHALL have port `busy`, output, 1 bit: high from accepted start until the last word transfers.
REQ-018 SHALL have port `done`, output, 1 bit: one-cycle pulse on the cycle after the last word transfers.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE and DRAIN.
REQ-020 IDLE: start=1 SHALL latch count_max, clear the issue address to 0 and enter ISSUE; busy SHALL rise the next cycle.
REQ-021 ISSUE: bram_en SHALL be 1 and bram_addr SHALL advance by 1 only when credit is available, i.e. fifo_count + in_flight < READ_LATENCY+2.
REQ-022 ISSUE: issuing address = latched count_max SHALL enter DRAIN; addresses 0..count_max SHALL be read exactly once, in order (count_max+1 words).
REQ-023 Read data SHALL enter an internal FIFO of depth READ_LATENCY+2 exactly READ_LATENCY cycles after its bram_en; a shift-register valid/last tag pipeline SHALL track in-flight reads.
REQ-024 The FIFO SHALL never overflow; the credit rule guarantees this under arbitrary tready.
REQ-025 m_axis_tvalid SHALL equal FIFO non-empty; a transfer SHALL occur on tvalid&&tready.
REQ-026 tdata and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-027 DRAIN: the transfer with tlast=1 SHALL return the FSM to IDLE, drop busy and pulse done the next cycle.
REQ-028 start SHALL be ignored while busy=1; count_max changes after acceptance SHALL have no effect.
REQ-029 count_max=0 SHALL give a single word with tlast=1.
REQ-030 count_max=2^BRAM_WIDTH-1 SHALL read the full BRAM with no address wrap past count_max.
REQ-031 With tready held 1, throughput SHALL be one word per cycle after the initial READ_LATENCY fill.
REQ-032 First tvalid SHALL occur READ_LATENCY+1 cycles after the start cycle.

Reset
REQ-033 resetn=0 SHALL asynchronously force IDLE, with bram_addr, bram_en, bram_we, m_axis_tvalid, m_axis_tlast, busy, done and the FIFO count all 0.
REQ-034 Reset mid-readout SHALL discard all in-flight and buffered words; a subsequent start SHALL begin again from address 0.

Configuration
REQ-035 Macro BRAM_READOUT_CLEAR_EN, when defined, SHALL make bram_we equal bram_en, clearing each address on read; BRAM is READ_FIRST, so old data is still returned.
REQ-036 Without BRAM_READOUT_CLEAR_EN, bram_we SHALL be tied to 0; bram_wdata SHALL be 0 in both builds.

Verification
REQ-037 BRAM model addr->addr+100, READ_LATENCY=2, count_max=7, tready=1 SHALL give tdata 100..107 on consecutive cycles, tlast on 107, first tvalid 3 cycles after start, and done once.
REQ-038 Same setup with tready toggling 1,0,0,1 repeating SHALL give tdata 100..107 in order with no loss or duplication and data stable while stalled.
REQ-039 count_max=0 SHALL give a single word 100 with tlast=1; done SHALL pulse on the next cycle.
REQ-040 A second start while busy, with count_max changed to 3 mid-run, SHALL be ignored; the run SHALL still deliver 8 words.
REQ-041 resetn pulsed low after 4 transfers, then start with count_max=2, SHALL give outputs 0 during reset, then 100,101,102 with tlast on 102.
REQ-042 With BRAM_READOUT_CLEAR_EN, count_max=3 SHALL give first-pass output 100..103 and second-pass output 0,0,0,0; without the macro both passes SHALL give 100..103.
